// File: rtl/ro_test_pkg.sv
// Shared definitions for the ETROC1 readout test pattern: word layout, header, FSM states, flag bits.
package ro_test_pkg;
  localparam logic [9:0] RO_HEADER = 10'b1010101010;
  localparam int WORD_W  = 30;
  localparam int HDR_MSB = 29;
  localparam int HDR_LSB = 20;
  localparam int ID_MSB  = 19;
  localparam int ID_LSB  = 16;
  localparam int CNT_MSB = 15;
  localparam int CNT_LSB = 0;
  localparam int ERR_HDR = 0;
  localparam int ERR_ID  = 1;
  localparam int ERR_CNT = 2;
  localparam int ERR_W   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } ro_state_t;
endpackage

// File: rtl/ro_word_check.sv
// Combinational field check of one test-pattern word against header, pixel ID and expected counter.
module ro_word_check
  import ro_test_pkg::*;
#(
  parameter logic [9:0] HEADER = RO_HEADER
) (
  input  logic [WORD_W-1:0] DataIn,
  input  logic [3:0]        ExpID,
  input  logic [15:0]       exp_cnt,
  output logic [ERR_W-1:0]  flags
);
  always_comb begin
    flags          = '0;
    flags[ERR_HDR] = (DataIn[HDR_MSB:HDR_LSB] != HEADER);
    flags[ERR_ID]  = (DataIn[ID_MSB:ID_LSB] != ExpID);
    flags[ERR_CNT] = (DataIn[CNT_MSB:CNT_LSB] != exp_cnt);
  end
endmodule

// File: rtl/ro_test_checker.sv
// Receive-side checker for the readout test pattern: lock FSM, counter tracking and error statistics.
module ro_test_checker
  import ro_test_pkg::*;
#(
  parameter logic [9:0] HEADER      = RO_HEADER,
  parameter int         LOCK_WORDS  = 4,
  parameter int         UNLOCK_ERRS = 3,
  parameter int         CNT_W       = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Enable,
  input  logic [3:0]          ExpID,
  input  logic                ClrCnt,
  input  logic                DataValid,
  input  logic [WORD_W-1:0]   DataIn,
  output logic                Locked,
  output logic                ErrPulse,
  output logic [ERR_W-1:0]    ErrFlags,
  output logic [CNT_W-1:0]    ErrCount,
  output logic [CNT_W-1:0]    WordCount,
  output logic [WORD_W-1:0]   LastBad
);
  localparam int GR_W = $clog2(LOCK_WORDS + 1);
  localparam int BR_W = $clog2(UNLOCK_ERRS + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  ro_state_t         state, state_n;
  logic [GR_W-1:0]   good_run, good_n;
  logic [BR_W-1:0]   bad_run, bad_n;
  logic [15:0]       exp_cnt, exp_n;
  logic [ERR_W-1:0]  flags;
  logic              hi_ok, bad_word, lock_chk;

  ro_word_check #(.HEADER(HEADER)) u_check (
    .DataIn  (DataIn),
    .ExpID   (ExpID),
    .exp_cnt (exp_cnt),
    .flags   (flags)
  );

  always_comb begin
    state_n  = state;
    good_n   = good_run;
    bad_n    = bad_run;
    exp_n    = exp_cnt;
    bad_word = 1'b0;
    lock_chk = 1'b0;
    hi_ok    = !flags[ERR_HDR] && !flags[ERR_ID];
    if (!Enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_n = ACQUIRE;
          good_n  = '0;
        end
        ACQUIRE: if (DataValid) begin
          // Resync the expected counter to every word while hunting for lock.
          if (hi_ok && (good_run == '0 || !flags[ERR_CNT])) good_n = good_run + GR_W'(1);
          else good_n = hi_ok ? GR_W'(1) : '0;
          exp_n = DataIn[CNT_MSB:CNT_LSB] + 16'd1;
          if (good_n == GR_W'(LOCK_WORDS)) begin
            state_n = LOCKED;
            bad_n   = '0;
          end
        end
        LOCKED: if (DataValid) begin
          lock_chk = 1'b1;
          exp_n    = exp_cnt + 16'd1;
          if (|flags) begin
            bad_word = 1'b1;
            bad_n    = bad_run + BR_W'(1);
            if (bad_n == BR_W'(UNLOCK_ERRS)) begin
              state_n = ACQUIRE;
              good_n  = '0;
            end
          end else begin
            bad_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      good_run <= '0;
      bad_run  <= '0;
      exp_cnt  <= '0;
      Locked   <= 1'b0;
    end else begin
      state    <= state_n;
      good_run <= good_n;
      bad_run  <= bad_n;
      exp_cnt  <= exp_n;
      Locked   <= (state_n == LOCKED);
    end
  end

  // Statistics: clear has priority over a same-cycle increment, but not over the pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ErrPulse  <= 1'b0;
      ErrFlags  <= '0;
      ErrCount  <= '0;
      WordCount <= '0;
      LastBad   <= '0;
    end else begin
      ErrPulse <= bad_word;
      if (bad_word) LastBad <= DataIn;
      if (ClrCnt) begin
        ErrFlags  <= '0;
        ErrCount  <= '0;
        WordCount <= '0;
      end else begin
        if (lock_chk) WordCount <= sat_inc(WordCount);
        if (bad_word) begin
          ErrCount <= sat_inc(ErrCount);
          ErrFlags <= ErrFlags | flags;
        end
      end
    end
  end
endmodule

// File: tb/tb_ro_test_checker.sv
// Directed bench for ro_test_checker with a per-cycle reference model and literal spot checks.
module tb_ro_test_checker;
  localparam int CNT_W       = 8;
  localparam int LOCK_WORDS  = 4;
  localparam int UNLOCK_ERRS = 3;
  localparam int MAXC        = (1 << CNT_W) - 1;
  localparam logic [9:0] HDR = 10'b1010101010;

  logic              CLK = 1'b0;
  logic              RST, Enable, ClrCnt, DataValid;
  logic [3:0]        ExpID;
  logic [29:0]       DataIn;
  logic              Locked, ErrPulse;
  logic [2:0]        ErrFlags;
  logic [CNT_W-1:0]  ErrCount, WordCount;
  logic [29:0]       LastBad;

  int errs = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  ro_test_checker #(
    .HEADER(HDR), .LOCK_WORDS(LOCK_WORDS), .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .Enable(Enable), .ExpID(ExpID), .ClrCnt(ClrCnt),
    .DataValid(DataValid), .DataIn(DataIn), .Locked(Locked), .ErrPulse(ErrPulse),
    .ErrFlags(ErrFlags), .ErrCount(ErrCount), .WordCount(WordCount), .LastBad(LastBad)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = waiting, 1 = hunting, 2 = locked.
  int          m_mode = 0, m_good = 0, m_bad = 0, m_ec = 0, m_wc = 0;
  logic [15:0] m_exp = '0;
  logic [2:0]  m_fl = '0;
  logic [29:0] m_last = '0;
  logic        m_pulse = 1'b0;
  logic        hb, ib, cb;

  always @(posedge CLK) begin
    if (RST) begin
      m_mode = 0; m_good = 0; m_bad = 0; m_ec = 0; m_wc = 0;
      m_exp = '0; m_fl = '0; m_last = '0; m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      hb = (DataIn[29:20] != HDR);
      ib = (DataIn[19:16] != ExpID);
      cb = (DataIn[15:0] != m_exp);
      if (!Enable) m_mode = 0;
      else if (m_mode == 0) begin
        m_mode = 1; m_good = 0;
      end else if (DataValid && m_mode == 1) begin
        if (!hb && !ib) m_good = (m_good == 0 || !cb) ? m_good + 1 : 1;
        else m_good = 0;
        m_exp = DataIn[15:0] + 16'd1;
        if (m_good == LOCK_WORDS) begin m_mode = 2; m_bad = 0; end
      end else if (DataValid && m_mode == 2) begin
        if (m_wc < MAXC) m_wc++;
        if (hb || ib || cb) begin
          m_pulse = 1'b1;
          if (m_ec < MAXC) m_ec++;
          m_fl = m_fl | {cb, ib, hb};
          m_last = DataIn;
          m_bad++;
          if (m_bad == UNLOCK_ERRS) begin m_mode = 1; m_good = 0; end
        end else m_bad = 0;
        m_exp = m_exp + 16'd1;
      end
      if (ClrCnt) begin m_ec = 0; m_wc = 0; m_fl = '0; end
    end
  end

  always @(negedge CLK) begin
    if (cmp_on) begin
      chk("m_locked", {31'd0, Locked}, {31'd0, m_mode == 2});
      chk("m_pulse", {31'd0, ErrPulse}, {31'd0, m_pulse});
      chk("m_flags", {29'd0, ErrFlags}, {29'd0, m_fl});
      chk("m_errcount", 32'(ErrCount), 32'(m_ec));
      chk("m_wordcount", 32'(WordCount), 32'(m_wc));
      chk("m_lastbad", {2'd0, LastBad}, {2'd0, m_last});
    end
  end

  function automatic logic [29:0] mk(input logic [9:0] h, input logic [3:0] id, input logic [15:0] c);
    return {h, id, c};
  endfunction

  task automatic send(input logic [29:0] w);
    DataIn = w; DataValid = 1'b1;
    @(posedge CLK); #2;
    DataValid = 1'b0;
  endtask

  task automatic gap(input int n);
    DataValid = 1'b0;
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  logic [15:0] c;

  initial begin
    RST = 1'b1; Enable = 1'b0; ExpID = 4'h5; ClrCnt = 1'b0; DataValid = 1'b0; DataIn = '0;
    repeat (2) @(posedge CLK); #2;
    cmp_on = 1'b1;
    chk("rst_locked", {31'd0, Locked}, 32'd0);
    chk("rst_errcount", 32'(ErrCount), 32'd0);
    chk("rst_lastbad", {2'd0, LastBad}, 32'd0);
    RST = 1'b0;

    // Acquire and lock on a clean stream
    Enable = 1'b1; gap(1);
    for (int i = 0; i < 3; i++) send(mk(HDR, 4'h5, 16'h0010 + 16'(i)));
    chk("t1_not_locked", {31'd0, Locked}, 32'd0);
    send(mk(HDR, 4'h5, 16'h0013));
    chk("t1_locked", {31'd0, Locked}, 32'd1);
    send(mk(HDR, 4'h5, 16'h0014));
    chk("t1_wordcount", 32'(WordCount), 32'd1);
    chk("t1_errcount", 32'(ErrCount), 32'd0);

    // Header corruption on one word
    send(mk(10'h2AB, 4'h5, 16'h0015));
    chk("t2_pulse", {31'd0, ErrPulse}, 32'd1);
    chk("t2_flags", {29'd0, ErrFlags}, 32'd1);
    chk("t2_errcount", 32'(ErrCount), 32'd1);
    chk("t2_lastbad", {2'd0, LastBad}, 32'h2AB50015);
    send(mk(HDR, 4'h5, 16'h0016));
    chk("t2_pulse_gone", {31'd0, ErrPulse}, 32'd0);
    chk("t2_still_locked", {31'd0, Locked}, 32'd1);

    // Disable, then relock just below the counter wrap
    Enable = 1'b0; gap(1);
    chk("t3_disabled", {31'd0, Locked}, 32'd0);
    chk("t3_wc_hold", 32'(WordCount), 32'd3);
    Enable = 1'b1; gap(1);
    c = 16'hFFFA;
    repeat (8) begin send(mk(HDR, 4'h5, c)); c++; end
    chk("t3_wrap_wc", 32'(WordCount), 32'd7);
    chk("t3_wrap_ec", 32'(ErrCount), 32'd1);

    // Wrong expected ID drops lock after three errors
    ClrCnt = 1'b1; gap(1); ClrCnt = 1'b0;
    ExpID = 4'h6;
    send(mk(HDR, 4'h5, 16'h0002));
    send(mk(HDR, 4'h5, 16'h0003));
    chk("t4_locked_2bad", {31'd0, Locked}, 32'd1);
    send(mk(HDR, 4'h5, 16'h0004));
    chk("t4_unlocked", {31'd0, Locked}, 32'd0);
    chk("t4_errcount", 32'(ErrCount), 32'd3);
    chk("t4_flags", {29'd0, ErrFlags}, 32'd2);
    send(mk(HDR, 4'h5, 16'h0005));
    send(mk(HDR, 4'h5, 16'h0006));
    ExpID = 4'h5;
    for (int i = 7; i < 10; i++) send(mk(HDR, 4'h5, 16'(i)));
    chk("t4_no_relock_yet", {31'd0, Locked}, 32'd0);
    send(mk(HDR, 4'h5, 16'h000A));
    chk("t4_relocked", {31'd0, Locked}, 32'd1);

    // Gapped stream, then a clear colliding with a bad word
    for (int i = 11; i < 15; i++) begin send(mk(HDR, 4'h5, 16'(i))); gap(1); end
    chk("t5_gap_ec", 32'(ErrCount), 32'd3);
    chk("t5_gap_wc", 32'(WordCount), 32'd7);
    ClrCnt = 1'b1;
    send(mk(10'h000, 4'h5, 16'h000F));
    ClrCnt = 1'b0;
    chk("t5_clr_ec", 32'(ErrCount), 32'd0);
    chk("t5_clr_pulse", {31'd0, ErrPulse}, 32'd1);
    send(mk(HDR, 4'h5, 16'h0099));
    chk("t5_cnt_flag", {29'd0, ErrFlags}, 32'd4);
    send(mk(HDR, 4'h5, 16'h0011));
    chk("t5_single_err", 32'(ErrCount), 32'd1);

    // Saturate both counters with alternating bad/good words
    c = 16'h0012;
    for (int i = 0; i < 260; i++) begin
      send(mk(10'h3FF, 4'h5, c)); c++;
      send(mk(HDR, 4'h5, c)); c++;
    end
    chk("sat_ec", 32'(ErrCount), 32'd255);
    chk("sat_wc", 32'(WordCount), 32'd255);
    chk("sat_flags", {29'd0, ErrFlags}, 32'd5);
    chk("sat_locked", {31'd0, Locked}, 32'd1);

    // Reset mid-stream with seven errors logged
    ClrCnt = 1'b1; gap(1); ClrCnt = 1'b0;
    repeat (7) begin
      send(mk(10'h3FF, 4'h5, c)); c++;
      send(mk(HDR, 4'h5, c)); c++;
    end
    chk("t6_ec7", 32'(ErrCount), 32'd7);
    RST = 1'b1; ClrCnt = 1'b1;
    send(mk(10'h3FF, 4'h5, c));
    chk("t6_rst_locked", {31'd0, Locked}, 32'd0);
    chk("t6_rst_ec", 32'(ErrCount), 32'd0);
    chk("t6_rst_wc", 32'(WordCount), 32'd0);
    chk("t6_rst_lastbad", {2'd0, LastBad}, 32'd0);
    RST = 1'b0; ClrCnt = 1'b0;
    gap(1);
    for (int i = 0; i < 4; i++) send(mk(HDR, 4'h5, 16'h0010 + 16'(i)));
    chk("t6_relock", {31'd0, Locked}, 32'd1);
    send(mk(HDR, 4'h5, 16'h0014));
    chk("t6_wc", 32'(WordCount), 32'd1);
    gap(2);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
